// File: rtl/tb_sim_ctrl.sv
// Simulation sequencer: per-channel reset sequencing, run window, cycle count, quiescence and watchdog.
// Optional feature: define SIM_CTRL_STAGGER_EN to release channel resets one per cycle.
module tb_sim_ctrl #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned QUIET_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [N_CH-1:0]  ch_busy,
    output logic [N_CH-1:0]  ch_reset,
    output logic             run,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("N_CH must be at least 1");
    end
    if (QUIET_CYCLES < 1) begin : g_bad_quiet
        $error("QUIET_CYCLES must be at least 1");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("RST_CYCLES must be at least 1");
    end

`ifdef SIM_CTRL_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    localparam int unsigned RST_W   = $clog2(RST_CYCLES + N_CH + 1);
    localparam int unsigned QUIET_W = $clog2(QUIET_CYCLES + 1);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_W-1:0]   TO_LAST    =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StRun,
        StDrain,
        StDone,
        StTout
    } state_e;

    state_e             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [QUIET_W-1:0] quiet_cnt_q, quiet_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [N_CH-1:0]    ch_reset_q, ch_reset_d;
    logic               run_q, run_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               wd_hit;
    logic [CNT_W-1:0]   cnt_inc;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        ch_reset_d  = ch_reset_q;
        wd_hit      = WD_EN && (cycle_cnt_q == TO_LAST);
        cnt_inc     = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

        unique case (state_q)
            StIdle: begin
                ch_reset_d = '1;
                if (start) begin
                    state_d   = StRst;
                    rst_cnt_d = '0;
                end
            end
            StRst: begin
                if (ch_reset_q == '0) begin
                    state_d   = StRun;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                    // A bit drops on the edge where the counter reaches its release point.
                    for (int unsigned i = 0; i < N_CH; i++) begin
                        if (32'(rst_cnt_d) == RST_CYCLES + (STAGGER ? i : 32'd0)) begin
                            ch_reset_d[i] = 1'b0;
                        end
                    end
                end
            end
            StRun: begin
                cycle_cnt_d = cnt_inc;
                if (wd_hit) begin
                    state_d = StTout;
                end else if (stop) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cycle_cnt_d = cnt_inc;
                if (wd_hit) begin
                    state_d = StTout;
                end else if (ch_busy == '0) begin
                    // X on ch_busy fails this compare and falls through as busy.
                    if (quiet_cnt_q == QUIET_LAST) begin
                        state_d = StDone;
                    end else begin
                        quiet_cnt_d = quiet_cnt_q + QUIET_W'(1);
                    end
                end else begin
                    quiet_cnt_d = '0;
                end
            end
            StDone, StTout: begin
                if (start) begin
                    state_d     = StRst;
                    rst_cnt_d   = '0;
                    quiet_cnt_d = '0;
                    cycle_cnt_d = '0;
                    ch_reset_d  = '1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        run_d     = (state_d == StRun) || (state_d == StDrain);
        done_d    = (state_d == StDone);
        timeout_d = (state_d == StTout);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rst_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            cycle_cnt_q <= '0;
            ch_reset_q  <= '1;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            ch_reset_q  <= ch_reset_d;
            run_q       <= run_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ch_reset  = ch_reset_q;
    assign run       = run_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
